average_filter_3x3: RTL and testbench

AVERAGE_FILTER_3X3 -- requirements
Module: average_filter_3x3

---
 rtl/average_filter_3x3_pkg.sv | 24 ++
 rtl/sum3.sv | 15 +
 rtl/average_filter_3x3.sv | 92 +++++++++
 tb/tb_average_filter_3x3.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/average_filter_3x3_pkg.sv
// rtl/average_filter_3x3_pkg.sv - shared widths and divide-by-9 constants
// Purpose: constants and the rounded divide-by-9 helper for the 3x3 mean filter.
// Ports: none (package).
package average_filter_3x3_pkg;

  localparam int PIX_W      = 8;
  localparam int ROW_SUM_W  = 10;
  localparam int SUM_W      = 12;
  localparam int DIV9_MUL   = 7282;
  localparam int DIV9_SHIFT = 16;
  localparam int ROUND_BIAS = 4;

  // (2295 + 4) * 7282 < 2^24, so a 25-bit product never overflows.
  localparam int PROD_W = SUM_W + 13;

  // Reciprocal multiply: ((sum + 4) * 7282) >> 16 == floor((sum + 4) / 9)
  // for every sum in 0..2295, which is round-to-nearest of sum / 9.
  function automatic logic [PIX_W-1:0] div9_round(input logic [SUM_W-1:0] sum);
    logic [PROD_W-1:0] prod;
    prod = (PROD_W'(sum) + PROD_W'(ROUND_BIAS)) * PROD_W'(DIV9_MUL);
    return prod[DIV9_SHIFT +: PIX_W];
  endfunction

endpackage

// File: rtl/sum3.sv
// rtl/sum3.sv - combinational three-pixel row adder
// Purpose: adds three 8-bit pixels into a 10-bit row sum that cannot overflow.
// Ports: a, b, c - pixels; sum - a + b + c.
module sum3
  import average_filter_3x3_pkg::*;
(
  input  logic [PIX_W-1:0]     a,
  input  logic [PIX_W-1:0]     b,
  input  logic [PIX_W-1:0]     c,
  output logic [ROW_SUM_W-1:0] sum
);

  assign sum = ROW_SUM_W'(a) + ROW_SUM_W'(b) + ROW_SUM_W'(c);

endmodule

// File: rtl/average_filter_3x3.sv
// rtl/average_filter_3x3.sv - three-stage 3x3 mean filter with threshold output
// Purpose: rounded mean of a 3x3 window plus a binarised result, after a warm-up
//   of WARMUP windows following each enable rise or reset.
// Ports: clk_100M, rst_n (async, active low), average_filter_en, in_valid,
//   matrix_p11..matrix_p33 (window, p22 centre), thresh;
//   avg_out, bin_out, avg_valid (strobe, three cycles after in_valid).
module average_filter_3x3 #(
  parameter int WARMUP = 2,
  parameter int PIX_W  = 8   // only 8 is supported
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             average_filter_en,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] matrix_p11,
  input  logic [PIX_W-1:0] matrix_p12,
  input  logic [PIX_W-1:0] matrix_p13,
  input  logic [PIX_W-1:0] matrix_p21,
  input  logic [PIX_W-1:0] matrix_p22,
  input  logic [PIX_W-1:0] matrix_p23,
  input  logic [PIX_W-1:0] matrix_p31,
  input  logic [PIX_W-1:0] matrix_p32,
  input  logic [PIX_W-1:0] matrix_p33,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] avg_out,
  output logic             bin_out,
  output logic             avg_valid
);

  import average_filter_3x3_pkg::*;

  localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(WARMUP);

  logic [ROW_SUM_W-1:0] row1_sum, row2_sum, row3_sum;
  logic [ROW_SUM_W-1:0] row1_q, row2_q, row3_q;
  logic [SUM_W-1:0]     sum_q;
  logic                 v1_q, v2_q;
  logic [CNT_W-1:0]     warm_cnt;
  logic                 accept;
  logic [PIX_W-1:0]     mean;

  sum3 u_row1 (.a(matrix_p11), .b(matrix_p12), .c(matrix_p13), .sum(row1_sum));
  sum3 u_row2 (.a(matrix_p21), .b(matrix_p22), .c(matrix_p23), .sum(row2_sum));
  sum3 u_row3 (.a(matrix_p31), .b(matrix_p32), .c(matrix_p33), .sum(row3_sum));

  // A window only enters the valid pipeline once warm-up has completed.
  assign accept = in_valid && average_filter_en && (warm_cnt == WARM_DONE);
  assign mean   = div9_round(sum_q);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      row1_q    <= '0;
      row2_q    <= '0;
      row3_q    <= '0;
      sum_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      avg_valid <= 1'b0;
      warm_cnt  <= '0;
      avg_out   <= '0;
      bin_out   <= 1'b0;
    end else begin
      // Data path free-runs; only the valid bits gate what becomes visible.
      row1_q <= row1_sum;
      row2_q <= row2_sum;
      row3_q <= row3_sum;
      sum_q  <= SUM_W'(row1_q) + SUM_W'(row2_q) + SUM_W'(row3_q);

      if (!average_filter_en) begin
        // Dropping enable flushes in-flight windows and restarts warm-up;
        // avg_out/bin_out keep their last value.
        v1_q      <= 1'b0;
        v2_q      <= 1'b0;
        avg_valid <= 1'b0;
        warm_cnt  <= '0;
      end else begin
        v1_q      <= accept;
        v2_q      <= v1_q;
        avg_valid <= v2_q;
        if (in_valid && (warm_cnt != WARM_DONE)) begin
          warm_cnt <= warm_cnt + 1'b1;
        end
        if (v2_q) begin
          avg_out <= mean;
          bin_out <= (mean >= thresh);  // thresh sampled live in this cycle
        end
      end
    end
  end

endmodule

// File: tb/tb_average_filter_3x3.sv
// tb/tb_average_filter_3x3.sv - scoreboard bench for average_filter_3x3
module tb_average_filter_3x3;

  localparam int WARMUP = 2;
  localparam int HIST   = 8192;

  logic       clk_100M = 1'b0;
  logic       rst_n;
  logic       average_filter_en;
  logic       in_valid;
  logic [7:0] px [9];
  logic [7:0] thresh;
  logic [7:0] avg_out;
  logic       bin_out;
  logic       avg_valid;

  always #5 clk_100M = ~clk_100M;

  average_filter_3x3 #(.WARMUP(WARMUP), .PIX_W(8)) dut (
    .clk_100M          (clk_100M),
    .rst_n             (rst_n),
    .average_filter_en (average_filter_en),
    .in_valid          (in_valid),
    .matrix_p11        (px[0]),
    .matrix_p12        (px[1]),
    .matrix_p13        (px[2]),
    .matrix_p21        (px[3]),
    .matrix_p22        (px[4]),
    .matrix_p23        (px[5]),
    .matrix_p31        (px[6]),
    .matrix_p32        (px[7]),
    .matrix_p33        (px[8]),
    .thresh            (thresh),
    .avg_out           (avg_out),
    .bin_out           (bin_out),
    .avg_valid         (avg_valid)
  );

  typedef struct {
    int due;
    int avg;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] thresh_hist [HIST];
  int         cyc = 0;
  int         seen = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         wsum;
  int         hold_avg = 0;
  int         hold_bin = 0;
  exp_t       e;
  int         eb;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a window counts only if enable/reset were clean when it
  // was sampled; the first WARMUP windows after a restart are discarded, and
  // any enable low or reset kills every window still in flight.
  always @(posedge clk_100M) begin
    if (cyc < HIST) thresh_hist[cyc] = thresh;
    if (!rst_n || !average_filter_en) begin
      sb.delete();
      seen = 0;
    end else if (in_valid) begin
      if (seen >= WARMUP) begin
        wsum = 0;
        for (int i = 0; i < 9; i++) wsum += int'(px[i]);
        sb.push_back('{cyc + 3, (wsum + 4) / 9});
      end else begin
        seen++;
      end
    end
    cyc++;
  end

  // Monitor: compares DUT outputs against the head of the scoreboard.
  always @(negedge clk_100M) begin
    if (!rst_n) begin
      hold_avg = 0;
      hold_bin = 0;
    end
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("missed_window", 0, 1);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      eb = (e.avg >= int'(thresh_hist[cyc-1])) ? 1 : 0;
      chk("avg_valid_hi", int'(avg_valid), 1);
      chk("avg_out", int'(avg_out), e.avg);
      chk("bin_out", int'(bin_out), eb);
      hold_avg = e.avg;
      hold_bin = eb;
    end else begin
      chk("avg_valid_lo", int'(avg_valid), 0);
      chk("avg_hold", int'(avg_out), hold_avg);
      chk("bin_hold", int'(bin_out), hold_bin);
    end
  end

  task automatic fill_uniform(input int v);
    for (int i = 0; i < 9; i++) px[i] = 8'(v);
  endtask

  task automatic fill_sum(input int s);
    int rem;
    rem = s;
    for (int i = 0; i < 9; i++) begin
      px[i] = 8'((rem > 255) ? 255 : rem);
      rem  -= int'(px[i]);
    end
  endtask

  task automatic send(input int th);
    @(negedge clk_100M);
    #2;
    in_valid = 1'b1;
    thresh   = 8'(th);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100M);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge clk_100M);
    #2;
    in_valid          = 1'b0;
    average_filter_en = v;
  endtask

  task automatic pulse_reset();
    @(negedge clk_100M);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_avg_out", int'(avg_out), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    @(negedge clk_100M);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    average_filter_en = 1'b0;
    in_valid          = 1'b0;
    thresh            = 8'd0;
    fill_uniform(0);
    repeat (3) @(negedge clk_100M);
    #1;
    chk("reset_avg_out", int'(avg_out), 0);
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_avg_valid", int'(avg_valid), 0);
    #1;
    rst_n = 1'b1;

    // Uniform window, warm-up then one valid output.
    set_en(1'b1);
    fill_uniform(100);
    repeat (3) send(100);
    idle(5);

    // Extremes and rounding.
    fill_uniform(255); send(0);
    fill_uniform(0);   send(1);
    fill_uniform(0); px[0] = 8'd13; send(0);
    px[0] = 8'd14; send(0);
    for (int i = 0; i < 9; i++) px[i] = 8'(i);
    send(5);
    idle(5);

    // Fresh warm-up: five pulses give three outputs.
    set_en(1'b0);
    set_en(1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 9; j++) px[j] = 8'($urandom_range(0, 255));
      send($urandom_range(0, 255));
    end
    idle(5);

    // Enable dropped one cycle after the fifth pulse, then a pulse with enable low.
    set_en(1'b0);
    set_en(1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 9; j++) px[j] = 8'($urandom_range(0, 255));
      send($urandom_range(0, 255));
    end
    set_en(1'b0);
    @(negedge clk_100M);
    #2;
    in_valid = 1'b1;
    idle(5);

    // Exhaustive sum sweep with a reset in the middle.
    set_en(1'b1);
    fill_sum(0);
    repeat (WARMUP) send(0);
    for (int s = 0; s <= 2295; s++) begin
      if (s == 1000) begin
        pulse_reset();
        fill_sum(0);
        repeat (WARMUP) send(0);
      end
      fill_sum(s);
      send($urandom_range(0, 255));
    end
    idle(5);

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_100M);
      #2;
      average_filter_en = ($urandom_range(0, 19) != 0);
      in_valid          = ($urandom_range(0, 3) != 0);
      thresh            = 8'($urandom_range(0, 255));
      for (int j = 0; j < 9; j++) px[j] = 8'($urandom_range(0, 255));
    end
    idle(6);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
